// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// The per-register busy scoreboard is built only when RFARB_SCOREBOARD_EN is defined.
package rf_ctrl_pkg;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int NUM_REGS = 32;

    // One writeback request: destination register and the value to write.
    typedef struct packed {
        logic [AW-1:0]   waddr;
        logic [XLEN-1:0] wdata;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters and the arbiter, plus the register
// file write triple and the debug grant index.
//
// Handshake: a source raises req_valid[i] with req_waddr[i]/req_wdata[i] and
// holds all three stable until req_ready[i]. The transfer happens at the
// posedge where req_valid[i] & req_ready[i] are both high. A source may drop
// req_valid before it is granted, in which case nothing is written.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = rf_ctrl_pkg::XLEN,
    parameter int AW      = rf_ctrl_pkg::AW
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0][AW-1:0]   req_waddr;
    logic [NUM_REQ-1:0][XLEN-1:0] req_wdata;
    logic                         rf_reg_wr;
    logic [AW-1:0]                rf_waddr;
    logic [XLEN-1:0]              rf_wdata;
    logic [GW-1:0]                grant_idx;

    modport slave (
        input  req_valid, req_waddr, req_wdata,
        output req_ready, rf_reg_wr, rf_waddr, rf_wdata, grant_idx
    );

    modport master (
        output req_valid, req_waddr, req_wdata,
        input  req_ready, rf_reg_wr, rf_waddr, rf_wdata, grant_idx
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer and wraps; the pointer
// moves just past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] idx;
    logic          found;

    // Priority search from the pointer, first asserted request wins.
    always_comb begin
        gnt     = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr_q) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                win_idx  = idx;
                found    = 1'b1;
            end
        end
        ptr_d = (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
    end

    // Pointer moves past the winner on a grant, holds otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among NUM_REQ writeback sources with a
// round-robin grant and a registered reg_wr/waddr/wdata triple.
// Define RFARB_SCOREBOARD_EN to build the per-register busy scoreboard used
// by the issue stage to stall on pending writebacks.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = rf_ctrl_pkg::XLEN,
    parameter int AW      = rf_ctrl_pkg::AW
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_wb_arbiter_if.slave   wb,
    input  logic                  claim_valid,
    input  logic [AW-1:0]         claim_addr,
    input  logic [AW-1:0]         qaddr1,
    input  logic [AW-1:0]         qaddr2,
    output logic                  busy1,
    output logic                  busy2
);
    import rf_ctrl_pkg::*;

    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] gnt;
    logic               granted;
    wb_req_t            sel;
    logic [GW-1:0]      sel_idx;

    logic               rf_reg_wr_q;
    logic [AW-1:0]      rf_waddr_q;
    logic [XLEN-1:0]    rf_wdata_q;
    logic [GW-1:0]      grant_idx_q;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (wb.req_valid),
        .advance (granted),
        .gnt     (gnt)
    );

    // The register file never backpressures, so the grant is the ready.
    assign wb.req_ready = gnt;
    assign granted      = |gnt;

    // Mux the winning source's request.
    always_comb begin
        sel     = '0;
        sel_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel.waddr = wb.req_waddr[i];
                sel.wdata = wb.req_wdata[i];
                sel_idx   = GW'(i);
            end
        end
    end

    // Register the write triple; x0 targets are accepted but never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_reg_wr_q <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            grant_idx_q <= '0;
        end else if (granted) begin
            rf_reg_wr_q <= (sel.waddr != '0);
            rf_waddr_q  <= sel.waddr;
            rf_wdata_q  <= sel.wdata;
            grant_idx_q <= sel_idx;
        end else begin
            rf_reg_wr_q <= 1'b0;
        end
    end

    assign wb.rf_reg_wr = rf_reg_wr_q;
    assign wb.rf_waddr  = rf_waddr_q;
    assign wb.rf_wdata  = rf_wdata_q;
    assign wb.grant_idx = grant_idx_q;

`ifdef RFARB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clear on the committing write, then set on a claim so a same-cycle claim wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_reg_wr_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (claim_valid && (claim_addr != '0)) begin
            busy_d[claim_addr] = 1'b1;
        end
    end

    // Busy vector state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // The write in flight this cycle is not yet readable, so it still counts as busy.
    assign busy1 = (qaddr1 != '0) &&
                   (busy_q[qaddr1] || (rf_reg_wr_q && (rf_waddr_q == qaddr1)));
    assign busy2 = (qaddr2 != '0) &&
                   (busy_q[qaddr2] || (rf_reg_wr_q && (rf_waddr_q == qaddr2)));
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{claim_valid, claim_addr, qaddr1, qaddr2};
    assign busy1 = 1'b0;
    assign busy2 = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run checked against a rule-level reference model.
// Define RFARB_SCOREBOARD_EN to check the busy scoreboard as well.
module tb_regfile_wb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int XLEN    = 32;
    localparam int AW      = 5;
`ifdef RFARB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          claim_valid;
    logic [AW-1:0] claim_addr;
    logic [AW-1:0] qaddr1;
    logic [AW-1:0] qaddr2;
    logic          busy1;
    logic          busy2;

    regfile_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .AW(AW)) wb ();

    regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb          (wb),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .qaddr1      (qaddr1),
        .qaddr2      (qaddr2),
        .busy1       (busy1),
        .busy2       (busy2)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- reference model ----------------
    int              m_ptr;
    bit              m_wr;
    logic [AW-1:0]   m_waddr;
    logic [XLEN-1:0] m_wdata;
    int              m_gidx;
    bit [31:0]       m_busy;
    logic [AW+XLEN-1:0] exp_q[$];

    task automatic model_reset();
        m_ptr   = 0;
        m_wr    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_gidx  = 0;
        m_busy  = '0;
    endtask

    // First valid source scanning from the pointer, -1 if none.
    function automatic int model_winner();
        for (int k = 0; k < NUM_REQ; k++) begin
            int s;
            s = (m_ptr + k) % NUM_REQ;
            if (wb.req_valid[s]) return s;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] model_ready();
        logic [NUM_REQ-1:0] r;
        int w;
        r = '0;
        w = model_winner();
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    function automatic bit model_busy(input logic [AW-1:0] q);
        if (!SB_EN || q == '0) return 1'b0;
        return m_busy[q] || (m_wr && m_waddr == q);
    endfunction

    // Apply one clock edge's worth of spec rules to the model.
    task automatic model_posedge();
        int            w;
        bit            old_wr;
        logic [AW-1:0] old_addr;
        w        = model_winner();
        old_wr   = m_wr;
        old_addr = m_waddr;
        if (w >= 0) begin
            m_wr    = (wb.req_waddr[w] != '0);
            m_waddr = wb.req_waddr[w];
            m_wdata = wb.req_wdata[w];
            m_gidx  = w;
            m_ptr   = (w + 1) % NUM_REQ;
        end else begin
            m_wr = 1'b0;
        end
        if (old_wr) m_busy[old_addr] = 1'b0;
        if (claim_valid && claim_addr != '0) m_busy[claim_addr] = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_posedge();
        #1;
    endtask

    task automatic idle_inputs();
        wb.req_valid = '0;
        wb.req_waddr = '0;
        wb.req_wdata = '0;
        claim_valid  = 1'b0;
        claim_addr   = '0;
        qaddr1       = '0;
        qaddr2       = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        tests_run++;
        if (wb.rf_reg_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rf_reg_wr: got %b expected 0", wb.rf_reg_wr);
        end
        tests_run++;
        if (wb.rf_waddr !== '0) begin
            tests_failed++;
            $display("FAIL reset_rf_waddr: got %0d expected 0", wb.rf_waddr);
        end
        tests_run++;
        if (wb.rf_wdata !== '0) begin
            tests_failed++;
            $display("FAIL reset_rf_wdata: got %h expected 0", wb.rf_wdata);
        end
        tests_run++;
        if (wb.grant_idx !== '0) begin
            tests_failed++;
            $display("FAIL reset_grant_idx: got %0d expected 0", wb.grant_idx);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_round_robin();
        int order[6] = '{0, 1, 2, 0, 1, 2};
        for (int s = 0; s < NUM_REQ; s++) begin
            wb.req_waddr[s] = AW'(s + 1);
            wb.req_wdata[s] = 32'hA000_0000 + 32'(s);
        end
        wb.req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            logic [NUM_REQ-1:0] exp_r;
            exp_r = '0;
            exp_r[order[c]] = 1'b1;
            #1;
            tests_run++;
            if (wb.req_ready !== exp_r || $countones(wb.req_ready) != 1) begin
                tests_failed++;
                $display("FAIL rr_ready[%0d]: got %b expected %b", c, wb.req_ready, exp_r);
            end
            tick();
            tests_run++;
            if (int'(wb.grant_idx) != order[c] || wb.rf_reg_wr !== 1'b1 ||
                wb.rf_waddr !== AW'(order[c] + 1)) begin
                tests_failed++;
                $display("FAIL rr_commit[%0d]: got idx=%0d wr=%b waddr=%0d expected idx=%0d wr=1 waddr=%0d",
                         c, wb.grant_idx, wb.rf_reg_wr, wb.rf_waddr, order[c], order[c] + 1);
            end
            @(negedge clk);
        end
        idle_inputs();
        tick();
        @(negedge clk);
    endtask

    task automatic test_single();
        wb.req_valid    = 3'b010;
        wb.req_waddr[1] = 5'd5;
        wb.req_wdata[1] = 32'hDEAD_BEEF;
        #1;
        tests_run++;
        if (wb.req_ready !== 3'b010) begin
            tests_failed++;
            $display("FAIL single_ready: got %b expected 010", wb.req_ready);
        end
        tick();
        tests_run++;
        if (wb.rf_reg_wr !== 1'b1 || wb.rf_waddr !== 5'd5 ||
            wb.rf_wdata !== 32'hDEAD_BEEF || wb.grant_idx !== 2'd1) begin
            tests_failed++;
            $display("FAIL single_commit: got wr=%b waddr=%0d wdata=%h idx=%0d expected wr=1 waddr=5 wdata=deadbeef idx=1",
                     wb.rf_reg_wr, wb.rf_waddr, wb.rf_wdata, wb.grant_idx);
        end
        @(negedge clk);
        idle_inputs();
        tick();
        tests_run++;
        if (wb.rf_reg_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_after: got wr=%b expected 0", wb.rf_reg_wr);
        end
        @(negedge clk);
    endtask

    task automatic test_x0();
        wb.req_valid    = 3'b001;
        wb.req_waddr[0] = '0;
        wb.req_wdata[0] = 32'h0000_1234;
        claim_valid     = 1'b1;
        claim_addr      = '0;
        qaddr1          = '0;
        #1;
        tests_run++;
        if (wb.req_ready !== 3'b001) begin
            tests_failed++;
            $display("FAIL x0_ready: got %b expected 001", wb.req_ready);
        end
        tick();
        tests_run++;
        if (wb.rf_reg_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL x0_suppress: got wr=%b expected 0", wb.rf_reg_wr);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (busy1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL x0_busy: got %b expected 0", busy1);
        end
        @(negedge clk);
    endtask

    task automatic test_scoreboard();
        claim_valid = 1'b1;
        claim_addr  = 5'd7;
        qaddr1      = 5'd7;
        qaddr2      = 5'd7;
        tick();
        @(negedge clk);
        claim_valid = 1'b0;
        #1;
        tests_run++;
        if (busy1 !== SB_EN) begin
            tests_failed++;
            $display("FAIL sb_claim: got busy1=%b expected %b", busy1, SB_EN);
        end
        // Write 7 while claiming 7 again in the commit cycle.
        wb.req_valid    = 3'b100;
        wb.req_waddr[2] = 5'd7;
        wb.req_wdata[2] = 32'h77;
        tick();
        @(negedge clk);
        wb.req_valid = '0;
        claim_valid  = 1'b1;
        claim_addr   = 5'd7;
        #1;
        tests_run++;
        if (wb.rf_reg_wr !== 1'b1 || busy1 !== SB_EN) begin
            tests_failed++;
            $display("FAIL sb_commit_claim: got wr=%b busy1=%b expected wr=1 busy1=%b", wb.rf_reg_wr, busy1, SB_EN);
        end
        tick();
        @(negedge clk);
        claim_valid = 1'b0;
        #1;
        tests_run++;
        if (busy1 !== SB_EN || busy2 !== SB_EN) begin
            tests_failed++;
            $display("FAIL sb_claim_wins: got busy1=%b busy2=%b expected %b", busy1, busy2, SB_EN);
        end
        // Write 7 with no claim: busy must drop after the commit edge.
        wb.req_valid    = 3'b001;
        wb.req_waddr[0] = 5'd7;
        wb.req_wdata[0] = 32'h88;
        tick();
        @(negedge clk);
        wb.req_valid = '0;
        #1;
        tests_run++;
        if (wb.rf_reg_wr !== 1'b1 || busy1 !== SB_EN) begin
            tests_failed++;
            $display("FAIL sb_commit: got wr=%b busy1=%b expected wr=1 busy1=%b", wb.rf_reg_wr, busy1, SB_EN);
        end
        tick();
        tests_run++;
        if (busy1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL sb_clear: got busy1=%b expected 0", busy1);
        end
        // Unclaimed register shows busy only while its write is in flight.
        @(negedge clk);
        qaddr2          = 5'd12;
        wb.req_valid    = 3'b010;
        wb.req_waddr[1] = 5'd12;
        wb.req_wdata[1] = 32'h12;
        tick();
        @(negedge clk);
        wb.req_valid = '0;
        #1;
        tests_run++;
        if (busy2 !== SB_EN) begin
            tests_failed++;
            $display("FAIL sb_inflight: got busy2=%b expected %b", busy2, SB_EN);
        end
        tick();
        tests_run++;
        if (busy2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL sb_inflight_done: got busy2=%b expected 0", busy2);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        int last_w;
        last_w = -1;
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            int w;
            for (int s = 0; s < NUM_REQ; s++) begin
                if (wb.req_valid[s] && s != last_w) begin
                    if ($urandom_range(0, 15) == 0) wb.req_valid[s] = 1'b0;
                end else begin
                    wb.req_valid[s] = ($urandom_range(0, 2) != 0);
                    wb.req_waddr[s] = AW'($urandom_range(0, 7));
                    wb.req_wdata[s] = $urandom;
                end
            end
            claim_valid = ($urandom_range(0, 3) == 0);
            claim_addr  = AW'($urandom_range(0, 7));
            qaddr1      = AW'($urandom_range(0, 7));
            qaddr2      = AW'($urandom_range(0, 7));
            #1;
            tests_run++;
            if (wb.req_ready !== model_ready()) begin
                tests_failed++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", c, wb.req_ready, model_ready());
            end
            tests_run++;
            if (busy1 !== model_busy(qaddr1) || busy2 !== model_busy(qaddr2)) begin
                tests_failed++;
                $display("FAIL rand_busy[%0d]: got %b%b expected %b%b", c, busy1, busy2,
                         model_busy(qaddr1), model_busy(qaddr2));
            end
            w = model_winner();
            if (w >= 0 && wb.req_waddr[w] != '0) exp_q.push_back({wb.req_waddr[w], wb.req_wdata[w]});
            last_w = w;
            tick();
            tests_run++;
            if (wb.rf_reg_wr !== m_wr || wb.rf_waddr !== m_waddr ||
                wb.rf_wdata !== m_wdata || int'(wb.grant_idx) != m_gidx) begin
                tests_failed++;
                $display("FAIL rand_rf[%0d]: got wr=%b a=%0d d=%h i=%0d expected wr=%b a=%0d d=%h i=%0d",
                         c, wb.rf_reg_wr, wb.rf_waddr, wb.rf_wdata, wb.grant_idx,
                         m_wr, m_waddr, m_wdata, m_gidx);
            end
            if (wb.rf_reg_wr === 1'b1) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rand_sb_extra[%0d]: got write a=%0d expected none", c, wb.rf_waddr);
                end else begin
                    logic [AW+XLEN-1:0] e;
                    e = exp_q.pop_front();
                    if ({wb.rf_waddr, wb.rf_wdata} !== e) begin
                        tests_failed++;
                        $display("FAIL rand_sb[%0d]: got %h expected %h", c, {wb.rf_waddr, wb.rf_wdata}, e);
                    end
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rand_sb_left: got %0d pending writes expected 0", exp_q.size());
        end
        idle_inputs();
        tick();
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        claim_valid     = 1'b1;
        claim_addr      = 5'd3;
        wb.req_valid    = 3'b010;
        wb.req_waddr[1] = 5'd9;
        wb.req_wdata[1] = 32'h55;
        tick();
        claim_valid  = 1'b0;
        wb.req_valid = '0;
        qaddr1       = 5'd3;
        #1;
        tests_run++;
        if (wb.rf_reg_wr !== 1'b1 || busy1 !== SB_EN) begin
            tests_failed++;
            $display("FAIL areset_pre: got wr=%b busy1=%b expected wr=1 busy1=%b", wb.rf_reg_wr, busy1, SB_EN);
        end
        #1;
        reset = 1'b0;
        #1;
        tests_run++;
        if (wb.rf_reg_wr !== 1'b0 || wb.rf_waddr !== '0 || wb.rf_wdata !== '0) begin
            tests_failed++;
            $display("FAIL areset_abort: got wr=%b a=%0d d=%h expected 0 0 0", wb.rf_reg_wr, wb.rf_waddr, wb.rf_wdata);
        end
        model_reset();
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        for (int q = 0; q < 32; q++) begin
            qaddr1 = AW'(q);
            #1;
            tests_run++;
            if (busy1 !== 1'b0) begin
                tests_failed++;
                $display("FAIL areset_busy[%0d]: got %b expected 0", q, busy1);
            end
        end
        @(negedge clk);
        wb.req_valid = 3'b111;
        #1;
        tests_run++;
        if (wb.req_ready !== 3'b001) begin
            tests_failed++;
            $display("FAIL areset_ptr: got %b expected 001", wb.req_ready);
        end
        tick();
        @(negedge clk);
        idle_inputs();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_x0();
        test_scoreboard();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 integer register file among NUM_REQ writeback sources, e.g. ALU result, load/cache-refill return and CSR read.
- Arbitration is round-robin with valid/ready handshakes.
- Drives a registered reg_wr/waddr/wdata triple straight into the register file write port.
- Optionally keeps a per-register busy scoreboard so the issue stage can stall on pending writebacks.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- XLEN, 32, data width.
- AW, 5, register address width (32 registers).

Ports:
- clk  input  1  core clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-source writeback request.
- req_ready  output  NUM_REQ  per-source grant; the transfer occurs on valid&ready at posedge.
- req_waddr  input  NUM_REQ x AW  per-source destination register.
- req_wdata  input  NUM_REQ x XLEN  per-source write data.
- rf_reg_wr  output  1  register file write enable.
- rf_waddr  output  AW  register file write address.
- rf_wdata  output  XLEN  register file write data.
- grant_idx  output  $clog2(NUM_REQ)  index of the source committed in the current rf_* cycle (debug/perf).
- claim_valid  input  1  issue stage reserves a destination register.
- claim_addr  input  AW  register being reserved.
- qaddr1, qaddr2  input  AW  source operands to check.
- busy1, busy2  output  1  the queried register has a pending writeback.

Behaviour:
- Reset (reset=0, asynchronous):
  - rf_reg_wr=0, rf_waddr=0, rf_wdata=0, grant_idx=0.
  - Round-robin pointer=0.
  - Scoreboard cleared.
  - req_ready is combinational and may be high during reset; handshakes are ignored while reset=0.
- Arbitration (combinational):
  - Search starts at the pointer index and wraps modulo NUM_REQ.
  - The first asserted req_valid gets req_ready=1; all other sources get 0.
  - At most one grant per cycle. req_ready never depends on rf state: the register file write port has no backpressure.
- Pointer update: on a grant at posedge, pointer <= (winner+1) mod NUM_REQ. With no grant the pointer holds.
- Fairness: a continuously valid source is granted within NUM_REQ cycles.
- Latency: a request granted at posedge N appears on rf_* for the whole of cycle N+1, so the register file's negedge write lands mid-cycle N+1.
- Output register:
  - rf_reg_wr = granted & (waddr != 0); writes to x0 are accepted (ready given) but suppressed.
  - rf_waddr/rf_wdata load only on a grant; otherwise they hold and rf_reg_wr=0.
- Same-address conflicts: two sources targeting the same register are serialized in grant order; the last granted value persists.
- Requesters must hold valid, waddr and wdata stable until ready (AXI-style). Dropping valid before ready is legal; nothing is written.
- Reset asserted mid-operation: the in-flight rf_* cycle is aborted (rf_reg_wr forced 0 immediately), and there are no pending grants afterwards.

Optional Feature:
- Macro: RFARB_SCOREBOARD_EN.
- Enabled:
  - 32-bit busy vector.
  - claim_valid & claim_addr!=0 sets busy[claim_addr] at posedge.
  - A committed write (rf_reg_wr=1) clears busy[rf_waddr] at the posedge ending that cycle.
  - Claim and clear of the same register in the same cycle: claim wins (stays busy).
  - Claiming an already-busy register keeps it busy.
  - busy1/busy2 = busy[qaddr]. They are combinational, with x0 always 0, and also assert when qaddr equals the rf_waddr currently being written (the write not yet visible to the reader).
- Disabled: no scoreboard flops; claim inputs ignored; busy1=busy2=0.

Decomposition:
- Package rf_ctrl_pkg:
  - XLEN, AW, NUM_REGS=32.
  - typedef wb_req_t {logic [AW-1:0] waddr; logic [XLEN-1:0] wdata;}.
- Sub-module rr_arbiter (parameter N): holds the pointer and priority search, with inputs req[N] and advance, and output one-hot gnt[N].

Test Plan:
- Single request, source1 valid, waddr=5, wdata=0xDEADBEEF at posedge N -> ready1=1 in cycle N; rf_reg_wr=1, rf_waddr=5, rf_wdata=0xDEADBEEF, grant_idx=1 in cycle N+1, then rf_reg_wr=0.
- All 3 sources valid for 6 cycles, pointer=0 -> grant order 0,1,2,0,1,2; no cycle with two readies.
- Source0 waddr=0, wdata=0x1234 -> ready0=1; next cycle rf_reg_wr=0. Scoreboard enabled: claim_addr=0 leaves busy1=0 for qaddr1=0.
- Scoreboard enabled: claim reg 7 -> busy1=1 for qaddr1=7. A later write to 7 with a simultaneous new claim of 7 -> busy stays 1. A write to 7 without a claim -> busy1=0 after that posedge.
- Reset pulled low asynchronously while rf_reg_wr=1 -> rf_reg_wr=0 immediately with no clock edge; after release, pointer=0 and busy vector all 0.
